cdc_handshake_arbiter: RTL and testbench
========================================

Name: cdc_handshake_arbiter

Overview:
- Source-domain controller that shares one toggle-based REQ/ACK CDC channel among NUM_REQ requesters.
- Arbitrates round-robin and launches one transfer at a time: stable data plus a request toggle.
- Waits for the returned, already-synchronized ack toggle, then retires the winner.
- Sits between requester logic and the CDC channel, in the channel's source clock domain.

Parameters:
- NUM_REQ, 4: number of requesters; must be >= 2.
- DATA_W, 8: payload width per transfer.
- TIMEOUT_CYCLES, 256: cycles allowed in WAIT_ACK before error; used only with the optional feature.

Ports:
- clk, input, 1: source-domain clock; the only clock.
- rst, input, 1: asynchronous, active-high reset.
- req_valid, input, NUM_REQ: per-requester transfer request; level; held until the matching req_ready.
- req_data, input, NUM_REQ*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready, output, NUM_REQ: one-hot, one-cycle pulse when requester i's transfer completes.
- xfer_data, output, DATA_W: payload presented to the channel; stable for the whole transfer.
- xfer_req_toggle, output, 1: request toggle into the channel.
- xfer_ack_toggle, input, 1: ack toggle from the destination, already two-flop synchronized into clk.
- busy, output, 1: high in any state other than IDLE.
- grant_id, output, $clog2(NUM_REQ): index of the current or last winner.
- proto_err, output, 1: sticky; ack toggle changed while not expected.
- timeout_err, output, 1: sticky; ack not received in time. Tied 0 when the feature is compiled out.

Behaviour:
- Reset values: all outputs 0; xfer_data 0; RR pointer 0; state IDLE.
- Reset is asynchronous, active-high, and may arrive mid-transfer; every register returns to its reset value.
- The destination side shares the same reset, so after reset both toggles are 0 and equal.
- FSM states: IDLE, WAIT_ACK, DONE, and ERROR (ERROR exists only with the feature).
- IDLE: if any req_valid is set, pick a winner combinationally, round-robin starting at the pointer. On the next edge:
  - grant_id <= winner;
  - xfer_data <= winner's slice of req_data;
  - xfer_req_toggle <= ~xfer_req_toggle;
  - go to WAIT_ACK.
  - Launch latency: 1 cycle from req_valid seen high.
- WAIT_ACK: when xfer_ack_toggle == xfer_req_toggle, go to DONE. xfer_data and grant_id are frozen.
- DONE (one cycle): req_ready[grant_id] = 1; pointer <= (grant_id+1) mod NUM_REQ; go to IDLE.
  - The next launch occurs no earlier than the cycle after DONE, so minimum spacing between launches is 3 cycles plus channel round trip.
- Arbitration example: pointer p gives priority order p, p+1, ..., wrapping at NUM_REQ-1 to 0.
- A requester dropping req_valid during WAIT_ACK is a protocol violation. The transfer still completes and req_ready still pulses.
- A change on xfer_ack_toggle while in IDLE or DONE sets proto_err (sticky until rst). The FSM otherwise continues.
- Only one req_ready bit is ever set, and only in DONE.

Optional Feature:
- Macro: CDC_HS_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle.
  - If it reaches TIMEOUT_CYCLES-1 without an ack, go to ERROR and set timeout_err.
  - ERROR holds busy=1, never pulses req_ready, ignores req_valid, and leaves only on rst.
  - An ack arriving in the same cycle the count expires wins: go to DONE, no error.
- Undefined: no counter, no ERROR state; WAIT_ACK waits indefinitely; timeout_err is constant 0.

Decomposition:
- Package cdc_hs_arb_pkg holds:
  - the state enum (IDLE, WAIT_ACK, DONE, ERROR);
  - localparam-style function grant_w(n) returning $clog2(n).
- One natural sub-module: cdc_hs_rr_pick, purely combinational.
  - Inputs: request vector and pointer.
  - Outputs: any-valid flag and winner index.
- Timeout counter and FSM stay in the top module.

Test Plan:
- Reset, then req_valid=4'b0001, data0=8'hA5; bench echoes ack 4 cycles after the toggle -> toggle 0->1 one cycle after valid; xfer_data=8'hA5; req_ready=4'b0001 pulses once; busy drops.
- req_valid=4'b1111 held, data i = 8'h10+i -> grants in order 0,1,2,3,0; xfer_data 8'h10, 11, 12, 13, 10; toggle flips once per transfer.
- Pointer at 2 after a grant to 1, req_valid=4'b0011 -> grant_id=0 first, then 1.
- Assert rst while in WAIT_ACK with toggle=1 -> all outputs 0 immediately; next request launches normally.
- Force xfer_ack_toggle 0->1 while IDLE -> proto_err=1 and stays 1 until rst; no req_ready.
- With CDC_HS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack -> timeout_err=1 after 16 WAIT_ACK cycles; busy stuck 1; further req_valid ignored. Without the macro, same stimulus -> stays in WAIT_ACK and timeout_err=0.

Source files
------------

// File: rtl/cdc_hs_arb_pkg.sv
// Shared types and helpers for the CDC handshake arbiter.
// The optional ack timeout is enabled with CDC_HS_ARB_TIMEOUT_EN; ERROR is
// only ever entered when that macro is defined.
package cdc_hs_arb_pkg;

  // Controller states; encoding is fixed so ERROR keeps a stable code in
  // both build flavours.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2,
    ERROR    = 2'd3
  } arb_state_t;

  // Width of a requester index; never returns 0 so a port always exists.
  function automatic int grant_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cdc_hs_rr_pick.sv
// Combinational round-robin picker: scans the request vector starting at
// ptr and wrapping at NUM_REQ-1, returning the first set index.
module cdc_hs_rr_pick
  import cdc_hs_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] ptr,
  output logic               any_valid,
  output logic [GRANT_W-1:0] winner
);

  int idx;

  // Priority scan p, p+1, ... with wrap; the first hit is kept.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned infers a latch.
    any_valid = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!any_valid && req[GRANT_W'(idx)]) begin
        any_valid = 1'b1;
        winner    = GRANT_W'(idx);
      end
    end
  end

endmodule

// File: rtl/cdc_handshake_arbiter.sv
// Source-domain controller sharing one toggle REQ/ACK CDC channel among
// NUM_REQ requesters. Round-robin arbitration, one transfer in flight,
// completion signalled by the already-synchronized ack toggle catching up
// with the request toggle.
// Optional feature macro: CDC_HS_ARB_TIMEOUT_EN (ack timeout -> ERROR).
module cdc_handshake_arbiter
  import cdc_hs_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_W-1:0]             xfer_data,
  output logic                          xfer_req_toggle,
  input  logic                          xfer_ack_toggle,
  output logic                          busy,
  output logic [grant_w(NUM_REQ)-1:0]   grant_id,
  output logic                          proto_err,
  output logic                          timeout_err
);

  localparam int GRANT_W = grant_w(NUM_REQ);

  // Elaboration-time guard on the parameter ranges the design relies on.
  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("cdc_handshake_arbiter: NUM_REQ and TIMEOUT_CYCLES must be >= 2");
  end

  arb_state_t           state_q;
  arb_state_t           state_d;
  logic [GRANT_W-1:0]   ptr_q;
  logic [GRANT_W-1:0]   grant_q;
  logic [GRANT_W-1:0]   pick_idx;
  logic [GRANT_W-1:0]   next_ptr;
  logic                 pick_any;
  logic [DATA_W-1:0]    data_q;
  logic                 req_tog_q;
  logic                 ack_q;
  logic                 proto_err_q;
  logic                 ack_match;
  logic                 ack_changed;
  logic                 launch;

  // Winner selection among the live requests, starting at the RR pointer.
  cdc_hs_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .any_valid (pick_any),
    .winner    (pick_idx)
  );

  // Transfer is complete once the returned ack toggle equals our request.
  assign ack_match   = (xfer_ack_toggle == req_tog_q);
  // Any edge of the ack toggle relative to last cycle's sample.
  assign ack_changed = (xfer_ack_toggle != ack_q);
  assign launch      = (state_q == IDLE) && pick_any;
  // Pointer moves to the requester just after the one served, with wrap.
  assign next_ptr    = (grant_q == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_q + GRANT_W'(1);

`ifdef CDC_HS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_hit;
  logic             timeout_err_q;

  assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count WAIT_ACK cycles; cleared on every launch into WAIT_ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else if (launch) begin
      wait_cnt_q <= '0;
    end else if (state_q == WAIT_ACK) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end

  // Sticky timeout flag, raised on the transition into ERROR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err_q <= 1'b0;
    end else if (state_q == WAIT_ACK && state_d == ERROR) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. An ack that lands on the expiry cycle still wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_match) begin
          state_d = DONE;
        end
`ifdef CDC_HS_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = ERROR;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      ERROR: begin
`ifdef CDC_HS_ARB_TIMEOUT_EN
        state_d = ERROR;
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    busy      = (state_q != IDLE);
    req_ready = '0;
    if (state_q == DONE) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  // Launch datapath: capture winner and payload, flip the request toggle.
  // Nothing here changes outside IDLE, so data and grant stay frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q   <= '0;
      data_q    <= '0;
      req_tog_q <= 1'b0;
    end else if (launch) begin
      grant_q   <= pick_idx;
      data_q    <= req_data[pick_idx*DATA_W +: DATA_W];
      req_tog_q <= ~req_tog_q;
    end
  end

  // Round-robin pointer advances only when a transfer retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (state_q == DONE) begin
      ptr_q <= next_ptr;
    end
  end

  // Ack edge monitor: an edge outside WAIT_ACK is a sticky protocol error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q       <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      ack_q <= xfer_ack_toggle;
      if (ack_changed && (state_q == IDLE || state_q == DONE)) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign grant_id        = grant_q;
  assign xfer_data       = data_q;
  assign xfer_req_toggle = req_tog_q;
  assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_cdc_handshake_arbiter.sv
// Directed bench for cdc_handshake_arbiter: table of single transfers plus
// hand-written sequences for async reset, stray ack and the ack timeout
// (behaviour selected by CDC_HS_ARB_TIMEOUT_EN).
module tb_cdc_handshake_arbiter;

  typedef struct {
    logic        rst_first;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [1:0]  exp_grant;
    logic [7:0]  exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  xfer_data;
  logic        xfer_req_toggle;
  logic        xfer_ack_toggle;
  logic        busy;
  logic [1:0]  grant_id;
  logic        proto_err;
  logic        timeout_err;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_tog  = 1'b0;
  vec_t vecs[13];

  always #5 clk = ~clk;

  cdc_handshake_arbiter #(
    .NUM_REQ        (4),
    .DATA_W         (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .xfer_data       (xfer_data),
    .xfer_req_toggle (xfer_req_toggle),
    .xfer_ack_toggle (xfer_ack_toggle),
    .busy            (busy),
    .grant_id        (grant_id),
    .proto_err       (proto_err),
    .timeout_err     (timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req_ready"},   req_ready, 0);
    check({tag, " xfer_data"},   xfer_data, 0);
    check({tag, " toggle"},      xfer_req_toggle, 0);
    check({tag, " busy"},        busy, 0);
    check({tag, " grant_id"},    grant_id, 0);
    check({tag, " proto_err"},   proto_err, 0);
    check({tag, " timeout_err"}, timeout_err, 0);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    req_valid       = '0;
    xfer_ack_toggle = 1'b0;
    tick();
    tick();
    rst     = 1'b0;
    exp_tog = 1'b0;
  endtask

  // One full transfer: launch, 4-cycle ack echo, DONE pulse, back to IDLE.
  task automatic run_xfer(input string tag, input logic [3:0] valid, input logic [31:0] data,
                          input logic [1:0] eg, input logic [7:0] ed);
    req_valid = valid;
    req_data  = data;
    tick();
    exp_tog = ~exp_tog;
    check({tag, " grant"},        grant_id, eg);
    check({tag, " data"},         xfer_data, ed);
    check({tag, " toggle"},       xfer_req_toggle, exp_tog);
    check({tag, " busy launch"},  busy, 1);
    check({tag, " ready early"},  req_ready, 0);
    req_data = ~data;
    for (int k = 0; k < 4; k++) tick();
    check({tag, " data frozen"},  xfer_data, ed);
    check({tag, " grant frozen"}, grant_id, eg);
    xfer_ack_toggle = exp_tog;
    tick();
    check({tag, " ready"},        req_ready, 4'b0001 << eg);
    check({tag, " busy done"},    busy, 1);
    req_valid[eg] = 1'b0;
    tick();
    check({tag, " ready clear"},  req_ready, 0);
    check({tag, " busy idle"},    busy, 0);
    req_data = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 4'b0001, 32'h0000_00A5, 2'd0, 8'hA5};
    vecs[1]  = '{1'b1, 4'b1111, 32'h1312_1110, 2'd0, 8'h10};
    vecs[2]  = '{1'b0, 4'b1111, 32'h1312_1110, 2'd1, 8'h11};
    vecs[3]  = '{1'b0, 4'b1111, 32'h1312_1110, 2'd2, 8'h12};
    vecs[4]  = '{1'b0, 4'b1111, 32'h1312_1110, 2'd3, 8'h13};
    vecs[5]  = '{1'b0, 4'b1111, 32'h1312_1110, 2'd0, 8'h10};
    vecs[6]  = '{1'b0, 4'b0010, 32'h1312_1110, 2'd1, 8'h11};
    vecs[7]  = '{1'b0, 4'b0011, 32'h1312_1110, 2'd0, 8'h10};
    vecs[8]  = '{1'b0, 4'b0010, 32'h1312_1110, 2'd1, 8'h11};
    vecs[9]  = '{1'b0, 4'b0001, 32'hDEAD_BEEF, 2'd0, 8'hEF};
    vecs[10] = '{1'b0, 4'b1000, 32'hDEAD_BEEF, 2'd3, 8'hDE};
    vecs[11] = '{1'b0, 4'b1100, 32'hDEAD_BEEF, 2'd2, 8'hAD};
    vecs[12] = '{1'b0, 4'b0101, 32'hDEAD_BEEF, 2'd0, 8'hEF};

    rst             = 1'b0;
    req_valid       = '0;
    req_data        = '0;
    xfer_ack_toggle = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_all_zero("reset");
    tick();
    tick();
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset();
      run_xfer($sformatf("v%0d", i), vecs[i].valid, vecs[i].data,
               vecs[i].exp_grant, vecs[i].exp_data);
    end
    check("table proto_err", proto_err, 0);

    // Asynchronous reset in the middle of WAIT_ACK with the toggle at 1.
    do_reset();
    req_valid = 4'b0100;
    req_data  = 32'hCAFE_F00D;
    tick();
    check("mid grant", grant_id, 2);
    check("mid data", xfer_data, 8'hFE);
    check("mid toggle", xfer_req_toggle, 1);
    tick();
    rst             = 1'b1;
    xfer_ack_toggle = 1'b0;
    req_valid       = '0;
    #1;
    check_all_zero("async rst");
    tick();
    tick();
    rst     = 1'b0;
    exp_tog = 1'b0;
    run_xfer("post rst", 4'b0010, 32'hCAFE_F00D, 2'd1, 8'hF0);

    // Stray ack edge while IDLE: sticky proto_err, no ready, no launch.
    xfer_ack_toggle = ~xfer_ack_toggle;
    tick();
    check("stray proto_err", proto_err, 1);
    check("stray ready", req_ready, 0);
    check("stray busy", busy, 0);
    for (int k = 0; k < 3; k++) tick();
    check("stray proto_err held", proto_err, 1);
    check("stray ready held", req_ready, 0);
    do_reset();
    check("proto_err cleared", proto_err, 0);

    // Missing ack.
    do_reset();
    req_valid = 4'b0001;
    req_data  = 32'h0000_0077;
    tick();
    exp_tog = ~exp_tog;
    check("noack launch", xfer_req_toggle, exp_tog);
`ifdef CDC_HS_ARB_TIMEOUT_EN
    for (int k = 0; k < 15; k++) tick();
    check("to before expiry", timeout_err, 0);
    check("to busy before", busy, 1);
    tick();
    check("to timeout_err", timeout_err, 1);
    check("to busy", busy, 1);
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) tick();
    check("err ready", req_ready, 0);
    check("err busy", busy, 1);
    check("err grant", grant_id, 0);
    check("err toggle", xfer_req_toggle, exp_tog);
    xfer_ack_toggle = exp_tog;
    tick();
    check("err late ack ready", req_ready, 0);
    check("err sticky", timeout_err, 1);

    // Ack landing on the expiry cycle wins.
    do_reset();
    req_valid = 4'b0001;
    tick();
    exp_tog = ~exp_tog;
    for (int k = 0; k < 15; k++) tick();
    xfer_ack_toggle = exp_tog;
    tick();
    check("race ready", req_ready, 4'b0001);
    check("race timeout_err", timeout_err, 0);
    req_valid = '0;
    tick();
    check("race idle", busy, 0);
`else
    // Requester drops valid mid-transfer; transfer still completes.
    req_valid = '0;
    for (int k = 0; k < 40; k++) tick();
    check("wait busy", busy, 1);
    check("wait timeout_err", timeout_err, 0);
    check("wait ready", req_ready, 0);
    check("wait data", xfer_data, 8'h77);
    xfer_ack_toggle = exp_tog;
    tick();
    check("late ack ready", req_ready, 4'b0001);
    tick();
    check("late ack idle", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
